// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared types and width helpers for the memory port arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    IC_BURST  = 2'd1,
    DC_ACCESS = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_IC = 1'b0,
    REQ_DC = 1'b1
  } requester_t;

  // Width of the beat counter for a burst of burst_len words.
  function automatic int beat_w(input int burst_len);
    return (burst_len <= 2) ? 1 : $clog2(burst_len);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_burst_addr_gen.sv
// burst_addr_gen: line-base capture, beat counter and last-beat flag for I-side refills.
// Latency: addr valid the cycle after load; advances one beat per accepted beat.
// Backpressure: counter holds while advance is low (mem_ready=0).
// Ports: load/load_addr capture a new line, advance steps one beat,
//        addr is the current beat byte address, last flags beat BURST_LEN-1.
module burst_addr_gen
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam int BEAT_W = beat_w(BURST_LEN);
  // Byte offset bits covered by one line: beat index plus word offset.
  localparam int OFF_W  = BEAT_W + 2;

  logic [ADDR_W-OFF_W-1:0] line_hi;
  logic [BEAT_W-1:0]       beat_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      line_hi  <= '0;
      beat_cnt <= '0;
    end else if (load) begin
      line_hi  <= load_addr[ADDR_W-1:OFF_W];
      beat_cnt <= '0;
    end else if (advance) begin
      // BURST_LEN is a power of two, so the natural wrap returns to 0 after the last beat.
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

  assign addr = {line_hi, beat_cnt, 2'b00};
  assign last = (beat_cnt == BEAT_W'(BURST_LEN - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin share of one memory port between I-cache refills and D-cache words.
// Latency: grant in IDLE cycle N, first beat N+1; IC done N+BURST_LEN, DC done N+1; one IDLE cycle after done.
// Backpressure: mem_ready=0 freezes mem_* outputs and the beat counter; each stall adds one cycle.
// Ports: ic_* refill requester (gnt/rvalid/rdata/done), dc_* single-word requester
//        (we/addr/wdata in, gnt/rvalid/rdata/done out), mem_* beat request to memory
//        with mem_ready/mem_rdata returned in the accepting cycle.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_gnt,
  output logic              ic_rvalid,
  output logic [DATA_W-1:0] ic_rdata,
  output logic              ic_done,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_gnt,
  output logic              dc_rvalid,
  output logic              dc_done,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t        state, state_nxt;
  requester_t        last_gnt;
  logic              dc_we_q;
  logic [ADDR_W-1:0] dc_addr_q;
  logic [DATA_W-1:0] dc_wdata_q;

  logic              ic_win, dc_win;
  logic [ADDR_W-1:0] burst_addr;
  logic              burst_last;

  // On a tie the side not granted last time wins.
  assign ic_win = (state == IDLE) && ic_req && (!dc_req || (last_gnt == REQ_DC));
  assign dc_win = (state == IDLE) && dc_req && (!ic_req || (last_gnt == REQ_IC));

  burst_addr_gen #(
    .ADDR_W    (ADDR_W),
    .BURST_LEN (BURST_LEN)
  ) u_addr_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (ic_win && reset_n),
    .load_addr (ic_addr),
    .advance   ((state == IC_BURST) && mem_ready),
    .addr      (burst_addr),
    .last      (burst_last)
  );

  // State register plus arbitration bookkeeping and D-side capture.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_gnt   <= REQ_IC;
      dc_we_q    <= 1'b0;
      dc_addr_q  <= '0;
      dc_wdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (ic_win) begin
        last_gnt <= REQ_IC;
      end else if (dc_win) begin
        last_gnt   <= REQ_DC;
        dc_we_q    <= dc_we;
        dc_addr_q  <= dc_addr;
        dc_wdata_q <= dc_wdata;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (ic_win)      state_nxt = IC_BURST;
        else if (dc_win) state_nxt = DC_ACCESS;
      end
      IC_BURST:  if (mem_ready && burst_last) state_nxt = IDLE;
      DC_ACCESS: if (mem_ready)               state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Outputs. Everything is forced low while reset_n is low so a beat that
  // completes during reset is dropped rather than reported.
  always_comb begin
    ic_gnt    = 1'b0;
    dc_gnt    = 1'b0;
    ic_rvalid = 1'b0;
    ic_rdata  = '0;
    ic_done   = 1'b0;
    dc_rvalid = 1'b0;
    dc_rdata  = '0;
    dc_done   = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (reset_n) begin
      unique case (state)
        IDLE: begin
          ic_gnt = ic_win;
          dc_gnt = dc_win;
        end
        IC_BURST: begin
          mem_req   = 1'b1;
          mem_addr  = burst_addr;
          ic_rvalid = mem_ready;
          ic_done   = mem_ready && burst_last;
          if (mem_ready) ic_rdata = mem_rdata;
        end
        DC_ACCESS: begin
          mem_req   = 1'b1;
          mem_we    = dc_we_q;
          mem_addr  = dc_addr_q;
          mem_wdata = dc_wdata_q;
          dc_done   = mem_ready;
          dc_rvalid = mem_ready && !dc_we_q;
          if (mem_ready && !dc_we_q) dc_rdata = mem_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, burst sequencing, stalls and reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled 3 units after it.
module tb_mem_port_arbiter;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int BURST_LEN = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              ic_req;
  logic [ADDR_W-1:0] ic_addr;
  logic              ic_gnt, ic_rvalid, ic_done;
  logic [DATA_W-1:0] ic_rdata;
  logic              dc_req, dc_we;
  logic [ADDR_W-1:0] dc_addr;
  logic [DATA_W-1:0] dc_wdata;
  logic              dc_gnt, dc_rvalid, dc_done;
  logic [DATA_W-1:0] dc_rdata;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .BURST_LEN (BURST_LEN)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ic_req    (ic_req),
    .ic_addr   (ic_addr),
    .ic_gnt    (ic_gnt),
    .ic_rvalid (ic_rvalid),
    .ic_rdata  (ic_rdata),
    .ic_done   (ic_done),
    .dc_req    (dc_req),
    .dc_we     (dc_we),
    .dc_addr   (dc_addr),
    .dc_wdata  (dc_wdata),
    .dc_gnt    (dc_gnt),
    .dc_rvalid (dc_rvalid),
    .dc_done   (dc_done),
    .dc_rdata  (dc_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling.
  task automatic settle();
    #2;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".ic_gnt"},    32'(ic_gnt),    32'd0);
    chk({tag, ".dc_gnt"},    32'(dc_gnt),    32'd0);
    chk({tag, ".mem_req"},   32'(mem_req),   32'd0);
    chk({tag, ".ic_rvalid"}, 32'(ic_rvalid), 32'd0);
    chk({tag, ".ic_done"},   32'(ic_done),   32'd0);
    chk({tag, ".dc_rvalid"}, 32'(dc_rvalid), 32'd0);
    chk({tag, ".dc_done"},   32'(dc_done),   32'd0);
  endtask

  // Stall table for the mid-burst stall test: cycles 1..6 after grant.
  logic        st_ready [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [31:0] st_addr  [6] = '{32'h1230, 32'h1234, 32'h1238, 32'h1238, 32'h1238, 32'h123C};
  logic        st_done  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    reset_n   = 1'b0;
    ic_req    = 1'b1;
    dc_req    = 1'b1;
    ic_addr   = 32'h0;
    dc_we     = 1'b0;
    dc_addr   = 32'h0;
    dc_wdata  = 32'h0;
    mem_ready = 1'b1;
    mem_rdata = 32'h0;

    // ---------------- reset with both requests high ----------------
    for (int i = 0; i < 2; i++) begin
      step();
      settle();
      chk_quiet("reset");
      chk("reset.mem_addr", mem_addr, 32'h0);
    end
    step();
    reset_n = 1'b1;
    ic_req  = 1'b0;
    dc_req  = 1'b0;
    settle();
    chk_quiet("idle_after_reset");

    // ---------------- tie after reset: DC first ----------------
    step();
    ic_req  = 1'b1;
    ic_addr = 32'h2004;
    dc_req  = 1'b1;
    dc_we   = 1'b0;
    dc_addr = 32'h40;
    settle();
    chk("tie1.dc_gnt", 32'(dc_gnt), 32'd1);
    chk("tie1.ic_gnt", 32'(ic_gnt), 32'd0);

    step();
    dc_req    = 1'b0;
    mem_rdata = 32'h5555_AAAA;
    settle();
    chk("tie1.mem_req",   32'(mem_req),   32'd1);
    chk("tie1.mem_we",    32'(mem_we),    32'd0);
    chk("tie1.mem_addr",  mem_addr,       32'h40);
    chk("tie1.dc_done",   32'(dc_done),   32'd1);
    chk("tie1.dc_rvalid", 32'(dc_rvalid), 32'd1);
    chk("tie1.dc_rdata",  dc_rdata,       32'h5555_AAAA);
    chk("tie1.ic_gnt_busy", 32'(ic_gnt),  32'd0);

    // Mandatory idle cycle after done: IC now wins even against a new DC request.
    step();
    dc_req = 1'b1;
    settle();
    chk("tie2.mem_req", 32'(mem_req), 32'd0);
    chk("tie2.ic_gnt",  32'(ic_gnt),  32'd1);
    chk("tie2.dc_gnt",  32'(dc_gnt),  32'd0);

    for (int b = 0; b < BURST_LEN; b++) begin
      step();
      ic_req    = 1'b0;
      mem_rdata = 32'hB000 + 32'(b);
      settle();
      chk("tie2.mem_addr",  mem_addr, 32'h2000 + 32'(4 * b));
      chk("tie2.ic_rvalid", 32'(ic_rvalid), 32'd1);
      chk("tie2.ic_rdata",  ic_rdata, 32'hB000 + 32'(b));
      chk("tie2.ic_done",   32'(ic_done), (b == BURST_LEN - 1) ? 32'd1 : 32'd0);
      chk("tie2.dc_gnt_busy", 32'(dc_gnt), 32'd0);
    end

    // Another tie: DC wins again since IC was granted last.
    step();
    ic_req = 1'b1;
    settle();
    chk("tie3.dc_gnt", 32'(dc_gnt), 32'd1);
    chk("tie3.ic_gnt", 32'(ic_gnt), 32'd0);
    step();
    ic_req = 1'b0;
    dc_req = 1'b0;
    settle();
    chk("tie3.dc_done", 32'(dc_done), 32'd1);
    step();
    settle();
    chk_quiet("tie3.idle");

    // ---------------- I-side refill alone ----------------
    step();
    ic_req  = 1'b1;
    ic_addr = 32'h0000_1234;
    settle();
    chk("ic.gnt", 32'(ic_gnt), 32'd1);
    for (int b = 0; b < BURST_LEN; b++) begin
      step();
      ic_req    = 1'b0;
      mem_rdata = 32'hC000 + 32'(b);
      settle();
      chk("ic.mem_req",  32'(mem_req), 32'd1);
      chk("ic.mem_we",   32'(mem_we),  32'd0);
      chk("ic.mem_addr", mem_addr, 32'h1230 + 32'(4 * b));
      chk("ic.rdata",    ic_rdata, 32'hC000 + 32'(b));
      chk("ic.done",     32'(ic_done), (b == BURST_LEN - 1) ? 32'd1 : 32'd0);
    end
    step();
    settle();
    chk_quiet("ic.idle");

    // ---------------- stall mid-burst ----------------
    step();
    ic_req  = 1'b1;
    ic_addr = 32'h0000_1234;
    settle();
    chk("stall.gnt", 32'(ic_gnt), 32'd1);
    for (int c = 0; c < 6; c++) begin
      step();
      ic_req    = 1'b0;
      mem_ready = st_ready[c];
      settle();
      chk("stall.mem_req",  32'(mem_req), 32'd1);
      chk("stall.mem_addr", mem_addr, st_addr[c]);
      chk("stall.rvalid",   32'(ic_rvalid), 32'(st_ready[c]));
      chk("stall.done",     32'(ic_done), 32'(st_done[c]));
    end
    step();
    mem_ready = 1'b1;
    settle();
    chk_quiet("stall.idle");

    // ---------------- D-side write ----------------
    step();
    dc_req   = 1'b1;
    dc_we    = 1'b1;
    dc_addr  = 32'h80;
    dc_wdata = 32'hDEAD_BEEF;
    settle();
    chk("wr.gnt", 32'(dc_gnt), 32'd1);
    step();
    dc_req   = 1'b0;
    dc_addr  = 32'hFFFF_FFFC;
    dc_wdata = 32'h0BAD_F00D;
    settle();
    chk("wr.mem_req",   32'(mem_req),   32'd1);
    chk("wr.mem_we",    32'(mem_we),    32'd1);
    chk("wr.mem_addr",  mem_addr,       32'h80);
    chk("wr.mem_wdata", mem_wdata,      32'hDEAD_BEEF);
    chk("wr.dc_done",   32'(dc_done),   32'd1);
    chk("wr.dc_rvalid", 32'(dc_rvalid), 32'd0);
    step();
    dc_we = 1'b0;
    settle();
    chk_quiet("wr.idle");

    // ---------------- reset mid-burst ----------------
    step();
    ic_req  = 1'b1;
    ic_addr = 32'h3000;
    settle();
    chk("rst.gnt", 32'(ic_gnt), 32'd1);
    for (int b = 0; b < 2; b++) begin
      step();
      ic_req = 1'b0;
      settle();
      chk("rst.mem_addr", mem_addr, 32'h3000 + 32'(4 * b));
    end
    step();
    reset_n = 1'b0;
    settle();
    chk_quiet("rst.during");
    step();
    reset_n = 1'b1;
    ic_req  = 1'b1;
    ic_addr = 32'h3008;
    dc_req  = 1'b1;
    dc_addr = 32'h44;
    settle();
    chk("rst.after.mem_req", 32'(mem_req), 32'd0);
    chk("rst.after.ic_done", 32'(ic_done), 32'd0);
    chk("rst.after.dc_gnt",  32'(dc_gnt),  32'd1);
    chk("rst.after.ic_gnt",  32'(ic_gnt),  32'd0);
    step();
    dc_req    = 1'b0;
    mem_rdata = 32'h1234_5678;
    settle();
    chk("rst.after.dc_rdata", dc_rdata, 32'h1234_5678);
    step();
    settle();
    chk("rst.after.ic_gnt2", 32'(ic_gnt), 32'd1);
    step();
    ic_req = 1'b0;
    settle();
    chk("rst.after.first_addr", mem_addr, 32'h3000);
    repeat (BURST_LEN) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
